// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: shadow slot, forward select, FSM state.
// Also holds the register-match helper used by the stall and forward compares.
package hazard_ctrl_pkg;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } slot_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_e;

    localparam slot_t BUBBLE = '0;

    // x0 never matches: a write to x0 carries no data.
    function automatic logic rd_hit(input logic [4:0] rd,
                                    input logic       we,
                                    input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM status in, stall/flush/forward out.
// master = pipeline datapath side, slave = hazard_ctrl side.
interface hazard_ctrl_if;

    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] RdD;
    logic       RegWriteD;
    logic       LoadD;
    logic       PCSrcE;
    logic       MemReadyM;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       MemErr;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE, MemReadyM,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemErr
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE, MemReadyM,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemErr
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX operand forward compare: MEM ALU result beats WB result beats register file.
// Ports: EX source indices, MEM/WB destination info in; A/B selects out.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs1_i,
    input  logic [4:0] ex_rs2_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_we_i,
    input  logic       mem_ld_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_we_i,
    output fwd_sel_e   fwd_a_o,
    output fwd_sel_e   fwd_b_o
);

    // A load's data is not available in MEM; only ALU results forward from there.
    logic mem_fwd_ok;
    assign mem_fwd_ok = mem_we_i & ~mem_ld_i;

    assign fwd_a_o = rd_hit(mem_rd_i, mem_fwd_ok, ex_rs1_i) ? FWD_MEM :
                     rd_hit(wb_rd_i,  wb_we_i,    ex_rs1_i) ? FWD_WB  :
                                                              FWD_RF;

    assign fwd_b_o = rd_hit(mem_rd_i, mem_fwd_ok, ex_rs2_i) ? FWD_MEM :
                     rd_hit(wb_rd_i,  wb_we_i,    ex_rs2_i) ? FWD_WB  :
                                                              FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB slots, stall/flush, memory timeout.
// Ports: clk, reset (async, active-high), hz (hazard_ctrl_if.slave). Macro HAZARD_FWD_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    slot_t         ex_q, mem_q, wb_q;
    slot_t         id_s, ex_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic          mem_err, freeze, hazard;
    fwd_sel_e      fwd_a, fwd_b;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w;

    assign id_s = '{rs1: hz.Rs1D, rs2: hz.Rs2D, rd: hz.RdD,
                    we: hz.RegWriteD, ld: hz.LoadD};

    assign mem_err = (state_q == ERR);
    // After a timeout the load is let through so the core can make progress.
    assign freeze  = mem_q.ld & ~hz.MemReadyM & ~mem_err;

`ifdef HAZARD_FWD_EN
    assign hazard = ex_q.ld &
                    (rd_hit(ex_q.rd, 1'b1, hz.Rs1D) |
                     rd_hit(ex_q.rd, 1'b1, hz.Rs2D));
`else
    // No bypass: wait until the producer reaches WB, where the
    // register file writes before it reads.
    assign hazard = rd_hit(ex_q.rd,  ex_q.we,  hz.Rs1D) |
                    rd_hit(ex_q.rd,  ex_q.we,  hz.Rs2D) |
                    rd_hit(mem_q.rd, mem_q.we, hz.Rs1D) |
                    rd_hit(mem_q.rd, mem_q.we, hz.Rs2D);
`endif

    hazard_fwd_unit u_fwd (
        .ex_rs1_i (ex_q.rs1),
        .ex_rs2_i (ex_q.rs2),
        .mem_rd_i (mem_q.rd),
        .mem_we_i (mem_q.we),
        .mem_ld_i (mem_q.ld),
        .wb_rd_i  (wb_q.rd),
        .wb_we_i  (wb_q.we),
        .fwd_a_o  (fwd_a),
        .fwd_b_o  (fwd_b)
    );

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (reset) begin
            stall_f = 1'b0;
        end else if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign ex_d = flush_e ? BUBBLE : id_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = freeze ? cnt_q + CW'(1) : '0;
        unique case (state_q)
            RUN: if (freeze && cnt_q == CW'(MAX_WAIT - 1)) state_d = ERR;
            ERR: state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_q    <= BUBBLE;
            cnt_q   <= '0;
            state_q <= RUN;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            if (!freeze) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
        end
    end

    assign hz.StallF = stall_f;
    assign hz.StallD = stall_d;
    assign hz.StallE = stall_e;
    assign hz.StallM = stall_m;
    assign hz.FlushD = flush_d;
    assign hz.FlushE = flush_e;
    assign hz.FlushW = flush_w;
    assign hz.MemErr = mem_err;

`ifdef HAZARD_FWD_EN
    assign hz.ForwardAE = reset ? FWD_RF : fwd_a;
    assign hz.ForwardBE = reset ? FWD_RF : fwd_b;

    logic unused_bits;
    assign unused_bits = ^{wb_q.rs1, wb_q.rs2, wb_q.ld};
`else
    assign hz.ForwardAE = FWD_RF;
    assign hz.ForwardBE = FWD_RF;

    logic unused_bits;
    assign unused_bits = ^{wb_q.rs1, wb_q.rs2, wb_q.ld, fwd_a, fwd_b};
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15, is the maximum consecutive freeze cycles tolerated for one load in MEM.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Rs1D, Rs2D, RdD  input  5 each  source and destination register indices of the instruction in ID.
REQ-005 RegWriteD, LoadD  input  1 each  ID instruction writes rd; ID instruction is a load.
REQ-006 PCSrcE  input  1  branch or jump taken, resolved in EX.
REQ-007 MemReadyM  input  1  data memory has completed the access for the instruction in MEM.
REQ-008 StallF, StallD, StallE, StallM  output  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-009 FlushD, FlushE, FlushW  output  1 each  clear the IF/ID, ID/EX (its clear input) and MEM/WB registers.
REQ-010 ForwardAE, ForwardBE  output  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result.
REQ-011 MemErr  output  1  sticky memory-timeout flag.

Function
REQ-012 The block SHALL keep shadow slots EX, MEM, WB, each holding {Rs1, Rs2, Rd, RegWrite, Load}.
REQ-013 Freeze = MEM.Load & ~MemReadyM & ~MemErr, combinational.
REQ-014 Freeze SHALL assert StallF, StallD, StallE and StallM and FlushW, deassert FlushD and FlushE, and hold all shadow slots.
REQ-015 Without Freeze, each edge SHALL shift WB<=MEM and MEM<=EX; EX SHALL load a bubble (all fields 0) if FlushE, otherwise the ID fields.
REQ-016 LoadUse = EX.Load & EX.Rd!=0 & (EX.Rd==Rs1D | EX.Rd==Rs2D).
REQ-017 When PCSrcE=1 and there is no Freeze, the block SHALL assert FlushD=FlushE=1, with no stalls, and this SHALL take priority over LoadUse.
REQ-018 When LoadUse=1 and there is no Freeze or branch, the block SHALL assert StallF=StallD=FlushE=1.
REQ-019 ForwardAE SHALL be 10 if MEM.RegWrite & ~MEM.Load & MEM.Rd!=0 & MEM.Rd==EX.Rs1; else 01 if WB.RegWrite & WB.Rd!=0 & WB.Rd==EX.Rs1; else 00.
REQ-020 ForwardBE SHALL follow the same rule using EX.Rs2.
REQ-021 Register x0 SHALL never cause a match, stall or forward.
REQ-022 The wait counter SHALL increment each Freeze cycle and clear on any non-Freeze cycle; the counter width is $clog2(MAX_WAIT+1).
REQ-023 FSM states RUN and ERR: when the counter equals MAX_WAIT-1 during Freeze, the state SHALL go RUN->ERR and MemErr SHALL be set; ERR is left only by reset.
REQ-024 In ERR, Freeze SHALL be suppressed, so the pending load completes and the pipeline advances; hazard and forward logic SHALL continue to operate.
REQ-025 All control outputs are combinational from the shadow state and inputs, so the stage registers act in the same cycle.

Reset
REQ-026 Reset SHALL clear all shadow slots to bubbles, set the counter to 0, the state to RUN and MemErr to 0.
REQ-027 While reset is asserted, all stall, flush and forward outputs SHALL be 0.
REQ-028 Reset asserted mid-freeze or mid-stall SHALL discard the pending condition immediately.

Configuration
REQ-029 Macro HAZARD_FWD_EN, when defined, SHALL compile in forwarding as specified in REQ-019 and REQ-020.
REQ-030 Without HAZARD_FWD_EN, ForwardAE and ForwardBE SHALL be tied to 00.
REQ-031 Without HAZARD_FWD_EN, LoadUse SHALL be replaced by RAW: ID rs (nonzero) equals EX.Rd or MEM.Rd with RegWrite set, causing the stall response of REQ-018; the register file writes before it reads in WB.

Structure
REQ-032 A shared package SHALL hold the slot struct typedef, the forward-select enum (FWD_RF, FWD_WB, FWD_MEM) and the FSM state enum.
REQ-033 One sub-module, hazard_fwd_unit, SHALL contain the combinational forwarding compare; the top level holds the slots, counter and FSM.

Verification
REQ-034 Scenario: add x5 then sub x6,x5,x1 back-to-back -> ForwardAE=10 in the sub's EX cycle, with no stall.
REQ-035 Scenario: lw x5 then add x7,x5,x5 -> one cycle of StallF=StallD=FlushE=1, then ForwardAE=ForwardBE=01.
REQ-036 Scenario: PCSrcE=1 in the same cycle as a LoadUse condition -> FlushD=FlushE=1 and StallF=0.
REQ-037 Scenario: lw in MEM with MemReadyM low for 3 cycles -> all stalls and FlushW high for exactly 3 cycles, slots unchanged, MemErr=0.
REQ-038 Scenario: MemReadyM held low with MAX_WAIT=4 -> freeze lasts 4 cycles, then MemErr=1 and the pipeline advances.
REQ-039 Scenario: rd=x0 producer followed by a consumer of x0 -> forward outputs 00 and no stall; assert reset mid-freeze -> all outputs 0 on the next sample.
